// File: rtl/eq_compare_arbiter_if.sv
// Bundle of the requester-side and status signals of the shared comparator.
// The arbiter takes the slave view; the requester side (or a bench) the master view.
interface eq_compare_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_bus;
  logic [NREQ*W-1:0] b_bus;
  logic [NREQ-1:0]   ack;
  logic              eq_out;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic [7:0]        cmp_count;
  logic [7:0]        match_count;

  modport master (
    output req, a_bus, b_bus,
    input  ack, eq_out, grant_id, busy, cmp_count, match_count
  );

  modport slave (
    input  req, a_bus, b_bus,
    output ack, eq_out, grant_id, busy, cmp_count, match_count
  );
endinterface

// File: rtl/eq_compare_arbiter.sv
// Round-robin arbiter that time-shares one W-bit equality comparator among
// NREQ requesters. One transaction is IDLE (grant + operand latch), CMP
// (registered compare), ACK (one-cycle acknowledge + counter update).
module eq_compare_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  eq_compare_arbiter_if.slave  io_bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_grant_id;
  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic            r_eq;
  logic [NREQ-1:0] r_ack;
  logic            r_eq_out;
  logic            r_busy;
  logic [7:0]      r_cmp_count;
  logic [7:0]      r_match_count;

  // Per-requester operand slices as arrays so the winner can index them.
  logic [W-1:0]    w_a_arr [NREQ];
  logic [W-1:0]    w_b_arr [NREQ];
  logic [IDW-1:0]  w_sel;
  logic            w_any;
  logic [IDW-1:0]  w_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign w_a_arr[gi] = io_bus.a_bus[gi*W +: W];
      assign w_b_arr[gi] = io_bus.b_bus[gi*W +: W];
    end
  endgenerate

  // Round-robin pick: first set req bit at or above rr_ptr, wrapping. The
  // search runs from the farthest offset down so the nearest one wins.
  always_comb begin
    logic [IDW-1:0] w_idx;
    w_sel = r_rr_ptr;
    w_any = |io_bus.req;
    w_idx = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      w_idx = IDW'((int'(r_rr_ptr) + off) % NREQ);
      if (io_bus.req[w_idx]) begin
        w_sel = w_idx;
      end
    end
  end

  // Pointer moves one past the requester just served, modulo NREQ.
  assign w_ptr_next = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + IDW'(1);

  // Transaction FSM; all outputs are registered here so they come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_eq          <= 1'b0;
      r_ack         <= '0;
      r_eq_out      <= 1'b0;
      r_busy        <= 1'b0;
      r_cmp_count   <= '0;
      r_match_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack    <= '0;
          r_eq_out <= 1'b0;
          if (w_any) begin
            r_op_a     <= w_a_arr[w_sel];
            r_op_b     <= w_b_arr[w_sel];
            r_grant_id <= w_sel;
            r_busy     <= 1'b1;
            r_state    <= S_CMP;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_CMP: begin
          // Result goes both to the status flop and to the ACK-cycle output.
          r_eq     <= (r_op_a == r_op_b);
          r_eq_out <= (r_op_a == r_op_b);
          r_ack    <= NREQ'(1) << r_grant_id;
          r_busy   <= 1'b1;
          r_state  <= S_ACK;
        end
        S_ACK: begin
          r_ack       <= '0;
          r_eq_out    <= 1'b0;
          r_busy      <= 1'b0;
          r_cmp_count <= r_cmp_count + 8'd1;
          if (r_eq && (r_match_count != 8'hFF)) begin
            r_match_count <= r_match_count + 8'd1;
          end
          r_rr_ptr <= w_ptr_next;
          r_state  <= S_IDLE;
        end
        default: begin
          r_ack    <= '0;
          r_eq_out <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.ack         = r_ack;
  assign io_bus.eq_out      = r_eq_out;
  assign io_bus.grant_id    = r_grant_id;
  assign io_bus.busy        = r_busy;
  assign io_bus.cmp_count   = r_cmp_count;
  assign io_bus.match_count = r_match_count;
endmodule

// File: tb/tb_eq_compare_arbiter.sv
// Scoreboard bench for eq_compare_arbiter: drivers push the expected compare
// result per request; a negedge monitor with a transaction-level model checks
// every cycle's outputs and pops results as acks appear.
module tb_eq_compare_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eq_compare_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  eq_compare_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct {
    int id;
    bit eq;
  } exp_t;

  exp_t            exp_q[$];
  int              errors = 0;
  int              checks = 0;
  logic [W-1:0]    op_a [NREQ];
  logic [W-1:0]    op_b [NREQ];
  logic [NREQ-1:0] ack_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.a_bus[i*W +: W] = op_a[i];
      bus.b_bus[i*W +: W] = op_b[i];
    end
  endtask

  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    op_a[i] = a;
    op_b[i] = b;
    pack_ops();
    bus.req[i] = 1'b1;
    e.id = i;
    e.eq = (a == b);
    exp_q.push_back(e);
    $display("ISSUE req%0d a=%h b=%h exp_eq=%0d", i, a, b, e.eq);
  endtask

  // Per-cycle requester behaviour: drop req on the edge that sees ack, and
  // optionally raise a fresh request with random operands.
  task automatic drive(input int ncyc, input int prob, input bit only_eq, input logic [NREQ-1:0] mask);
    logic [W-1:0] a, b;
    repeat (ncyc) begin
      @(negedge clk);
      ack_seen = bus.ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && ack_seen[i]) bus.req[i] = 1'b0;
        if (!bus.req[i] && mask[i] && ($urandom_range(99) < prob)) begin
          a = W'($urandom);
          b = (only_eq || ($urandom_range(1) == 1)) ? a : W'($urandom);
          raise(i, a, b);
        end
      end
    end
  endtask

  // Serve one request from requester i and wait (bounded) for its ack.
  task automatic serve_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got;
    got = 1'b0;
    raise(i, a, b);
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      got = bus.ack[i];
    end
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: requester %0d got no ack within 8 cycles", i);
    end
    @(posedge clk);
    #1;
    bus.req[i] = 1'b0;
  endtask

  // Reference model: a free comparator accepts the round-robin winner in an
  // IDLE cycle; the result appears two cycles later for exactly one cycle.
  int         m_left  = 0;
  int         m_win   = 0;
  int         m_last  = 0;
  int         m_ptr   = 0;
  int         m_cmp   = 0;
  int         m_match = 0;

  always @(negedge clk) begin
    int   k;
    int   idx;
    bit   found;
    bit   e_eq;
    if (rst) begin
      chk("rst_ack", 32'(bus.ack), 0);
      chk("rst_eq_out", 32'(bus.eq_out), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_grant_id", 32'(bus.grant_id), 0);
      chk("rst_cmp_count", 32'(bus.cmp_count), 0);
      chk("rst_match_count", 32'(bus.match_count), 0);
      m_left = 0; m_win = 0; m_last = 0; m_ptr = 0; m_cmp = 0; m_match = 0;
    end else begin
      chk("cmp_count", 32'(bus.cmp_count), 32'(m_cmp));
      chk("match_count", 32'(bus.match_count), 32'(m_match));
      if (m_left == 0) begin
        chk("idle_ack", 32'(bus.ack), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_eq_out", 32'(bus.eq_out), 0);
        chk("idle_grant_id", 32'(bus.grant_id), 32'(m_last));
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
          idx = (m_ptr + off) % NREQ;
          if (!found && bus.req[idx]) begin
            found = 1'b1;
            m_win = idx;
          end
        end
        if (found) begin
          m_last = m_win;
          m_left = 2;
        end
      end else if (m_left == 2) begin
        chk("cmp_busy", 32'(bus.busy), 1);
        chk("cmp_ack", 32'(bus.ack), 0);
        chk("cmp_eq_out", 32'(bus.eq_out), 0);
        chk("cmp_grant_id", 32'(bus.grant_id), 32'(m_win));
        m_left = 1;
      end else begin
        chk("ack_onehot", 32'(bus.ack), 32'(1) << m_win);
        chk("ack_busy", 32'(bus.busy), 1);
        chk("ack_grant_id", 32'(bus.grant_id), 32'(m_win));
        k = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
          if (k < 0 && exp_q[j].id == m_win) k = j;
        end
        e_eq = 1'b0;
        if (k < 0) begin
          checks++;
          errors++;
          $display("FAIL no_pending: ack for requester %0d with no outstanding request", m_win);
        end else begin
          e_eq = exp_q[k].eq;
          chk("eq_out", 32'(bus.eq_out), 32'(e_eq));
          exp_q.delete(k);
        end
        $display("ACK id=%0d eq_out=%0d expected=%0d cmp=%0d match=%0d",
                 m_win, bus.eq_out, e_eq, m_cmp, m_match);
        m_cmp = (m_cmp + 1) % 256;
        if (e_eq && m_match < 255) m_match++;
        m_ptr  = (m_win + 1) % NREQ;
        m_left = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    bus.req = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    pack_ops();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single equal pair, then single unequal pair.
    raise(0, 4'b0010, 4'b0010);
    drive(6, 0, 1'b0, '0);
    raise(2, 4'b1001, 4'b0000);
    drive(6, 0, 1'b0, '0);
    chk("drain_single", 32'(exp_q.size()), 0);
    chk("single_cmp", 32'(bus.cmp_count), 2);
    chk("single_match", 32'(bus.match_count), 1);

    // All four requesting from reset.
    do_reset();
    raise(0, 4'b0000, 4'b0000);
    raise(1, 4'b0001, 4'b1000);
    raise(2, 4'b1111, 4'b1111);
    raise(3, 4'b1001, 4'b0000);
    drive(15, 0, 1'b0, '0);
    chk("drain_all4", 32'(exp_q.size()), 0);
    chk("all4_cmp", 32'(bus.cmp_count), 4);
    chk("all4_match", 32'(bus.match_count), 2);

    // Fairness: after a grant to 2, requesters 0 and 3 together -> 3 first.
    raise(2, 4'h3, 4'h4);
    drive(6, 0, 1'b0, '0);
    raise(0, 4'h5, 4'h5);
    raise(3, 4'h6, 4'h7);
    drive(10, 0, 1'b0, '0);
    chk("drain_fair", 32'(exp_q.size()), 0);

    // Reset during CMP of requester 1; req stays high across reset.
    raise(1, 4'hA, 4'hA);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_in_cmp", 32'(bus.busy && (bus.ack == 0)), 1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    drive(8, 0, 1'b0, '0);
    chk("drain_rst_cmp", 32'(exp_q.size()), 0);
    chk("post_rst_cmp", 32'(bus.cmp_count), 1);

    // Randomized traffic.
    drive(600, 40, 1'b0, 4'hF);
    drive(30, 0, 1'b0, '0);
    chk("drain_random", 32'(exp_q.size()), 0);

    // Counter wrap and saturation.
    do_reset();
    for (int t = 0; t < 257; t++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      serve_one(0, v, v);
      if (t == 255) begin
        @(negedge clk);
        chk("wrap_cmp", 32'(bus.cmp_count), 0);
        chk("sat_match", 32'(bus.match_count), 255);
      end
    end
    @(negedge clk);
    chk("wrap_cmp_plus1", 32'(bus.cmp_count), 1);
    chk("sat_match_hold", 32'(bus.match_count), 255);
    chk("drain_sat", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/eq_compare_arbiter.md
# eq_compare_arbiter

Round-robin arbiter and sequencer that shares a single W-bit equality comparator among NREQ requesters. Each requester presents an operand pair and holds a request. The block grants one requester at a time, latches its operands and performs the registered compare. It then returns the result with a one-cycle acknowledge. It also keeps running totals of compares performed and matches found for debug and status readout.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 4, operand width in bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester request level; bit i belongs to requester i
- a_bus  input  NREQ*W  operand A of requester i at bits [i*W +: W]
- b_bus  input  NREQ*W  operand B of requester i at bits [i*W +: W]
- ack  output  NREQ  one-hot, one-cycle completion pulse to the granted requester
- eq_out  output  1  compare result (1 = A equals B); valid only while any ack bit is high
- grant_id  output  $clog2(NREQ)  index of the current or last granted requester
- busy  output  1  high in CMP and ACK states
- cmp_count  output  8  total compares completed; wraps from 255 to 0
- match_count  output  8  total compares with eq_out=1; saturates at 255

## Operation
- FSM states: IDLE, CMP, ACK.
- **IDLE**
  - If req==0, the FSM stays in IDLE.
  - Otherwise the block selects the first set req bit, searching upward from rr_ptr and wrapping modulo NREQ. It latches op_a/op_b from that requester's slice, sets grant_id to the winner and moves to CMP.
- **CMP**
  - eq_r <= (op_a == op_b), full W-bit compare with no sign interpretation.
  - The FSM moves to ACK.
- **ACK**
  - ack[grant_id]=1 and eq_out=eq_r.
  - On the exiting edge: cmp_count increments, match_count increments if eq_r and below 255, and rr_ptr <= (grant_id+1) mod NREQ.
  - The FSM then moves to IDLE.
- req is not sampled in CMP or ACK, and operand changes after the latch are ignored.
- Requester protocol:
  - Hold req and operands stable until ack is seen.
  - Deassert req on the clock edge that samples ack=1.
  - A requester that keeps req high is re-arbitrated on the next IDLE cycle under normal round-robin.
- Fairness: a requester waits at most NREQ-1 transactions once its req is high.
- Outputs decode from registered state: ack, eq_out and busy are glitch-free functions of state flops.
- eq_out=0 whenever ack==0.

## Timing
- Each transaction takes exactly 3 cycles (IDLE grant, CMP, ACK). Peak throughput is 1 compare per 3 cycles.
- Latency: req sampled high at IDLE edge k gives ack high during the cycle following edge k+1, and the FSM returns to IDLE at edge k+2.
- Back-to-back: with req pending, the next grant occurs at edge k+3 (the IDLE cycle), so no IDLE cycle is skipped.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0.
  - ack=0, eq_out=0, busy=0.
  - cmp_count=0, match_count=0.
  - op_a=op_b=0, eq_r=0.
- Reset mid-transaction (CMP or ACK): the transaction is abandoned, no ack is issued and counters are cleared. The requester must keep req high to be re-served after reset release.
- Simultaneous requests from reset: grant order is 0,1,…,NREQ-1,0,…
- Counter boundaries:
  - cmp_count 255 -> 0 on the next completion.
  - match_count stays at 255.
  - Both update on the same edge as the ACK exit.

## Test plan
- Single equal pair: req[0]=1, A0=4'b0010, B0=4'b0010 -> ack=4'b0001 two cycles after the sampling edge, eq_out=1, cmp_count=1, match_count=1.
- Single unequal pair: req[2]=1, A2=4'b1001, B2=4'b0000 -> ack=4'b0100, eq_out=0, grant_id=2, match_count unchanged, cmp_count+1.
- All four requesting from reset with (0000,0000), (0001,1000), (1111,1111), (1001,0000) -> acks in order 0,1,2,3, spaced 3 cycles apart, with eq_out 1,0,1,0. Final counts: cmp=4, match=2.
- Fairness: after a grant to 2, raise req[0] and req[3] together -> 3 is granted first, then 0.
- Reset asserted during CMP for requester 1 -> no ack pulse and all outputs at reset values. With req[1] still high after release -> ack[1] exactly 3 cycles later.
- Saturation/wrap: 256 equal compares -> cmp_count=0, match_count=255. One more equal compare -> cmp_count=1, match_count=255.
